// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//
// SPI mode 0 (CPOL=0, CPHA=0) slave that is oversampled by the system clock.
// cs, sck and mosi are asynchronous to clk. Each one passes through a 2-flop
// synchronizer. cs and sck edges are found by comparing the synchronized
// value with one extra delay flop. Frames are DATA_W bits long and MSB first.
// Several frames can be sent back to back inside one cs assertion.
//
// A one-word transmit buffer sits in front of the TX shift register. The
// register takes the buffered word at the start of every frame. If the buffer
// is empty at that moment, the register takes IDLE_FILL and tx_underrun
// pulses for one cycle.
//
// Ports
//   clk         system clock, at least 8x the sck frequency
//   rst_n       asynchronous active-low reset
//   cs          chip select from the master, active-low, asynchronous
//   sck         serial clock from the master, asynchronous
//   mosi        serial data from the master
//   miso        serial data to the master (0 when not selected)
//   miso_oe     miso drive enable, high only while selected
//   tx_data     word to send in the next frame
//   tx_valid    tx_data is valid
//   tx_ready    transmit buffer is empty and can accept a word
//   rx_data     last complete received word
//   rx_valid    one-cycle pulse: rx_data has been updated
//   frame_err   one-cycle pulse: cs deasserted in the middle of a frame
//   tx_underrun one-cycle pulse: a frame started with an empty buffer
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_FILL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // Synchronizers and edge detectors
  // -------------------------------------------------------------------------
  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic sck_meta_q, sck_sync_q, sck_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  // The reset values describe a deselected bus: cs high, sck low, mosi low.
  // These flops only retime the pins, so they load directly from their inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall;

  always_comb begin
    cs_fall  =  cs_dly_q  & ~cs_sync_q;
    cs_rise  = ~cs_dly_q  &  cs_sync_q;
    sck_rise = ~sck_dly_q &  sck_sync_q;
    sck_fall =  sck_dly_q & ~sck_sync_q;
  end

  // -------------------------------------------------------------------------
  // State machine: state register / next state / outputs
  // -------------------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              wrap_q, wrap_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_valid_q, buf_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= '0;
      wrap_q        <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      buf_data_q    <= '0;
      buf_valid_q   <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      wrap_q        <= wrap_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
      buf_data_q    <= buf_data_d;
      buf_valid_q   <= buf_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame control events
  // -------------------------------------------------------------------------
  // A cs rising edge takes priority over an sck edge detected in the same
  // cycle. If the master drops sck together with cs at the end of a frame,
  // that last falling edge does not start a new word load.
  // wrap_q marks that a full word was just received. The next sck falling
  // edge then loads the following word, which gives back-to-back frames.
  logic start_frame, end_frame, active_run, load_tx, capture;
  logic [DATA_W-1:0] rx_next;

  always_comb begin
    start_frame = (state_q == ST_IDLE)   & cs_fall;
    end_frame   = (state_q == ST_ACTIVE) & cs_rise;
    active_run  = (state_q == ST_ACTIVE) & ~cs_rise;
    load_tx     = start_frame | (active_run & sck_fall & wrap_q);
    capture     = tx_valid & ~buf_valid_q;
    rx_next     = DATA_W'({rx_shift_q, mosi_sync_q});
  end

  // -------------------------------------------------------------------------
  // Transmit buffer
  // -------------------------------------------------------------------------
  // A capture can only happen while the buffer is empty. So when a capture
  // and a load happen in the same cycle, the load finds the buffer empty and
  // the capture still fills it.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (load_tx) begin
      buf_valid_d = 1'b0;
    end
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_data_d  = tx_data;
    end
  end

  // -------------------------------------------------------------------------
  // TX shift register
  // -------------------------------------------------------------------------
  always_comb begin
    tx_shift_d    = tx_shift_q;
    tx_underrun_d = 1'b0;
    if (load_tx) begin
      if (buf_valid_q) begin
        tx_shift_d = buf_data_q;
      end else begin
        tx_shift_d    = IDLE_FILL;
        tx_underrun_d = 1'b1;
      end
    end else if (active_run && sck_fall) begin
      tx_shift_d = tx_shift_q << 1;
    end
  end

  // -------------------------------------------------------------------------
  // RX shift register, bit counter and frame error
  // -------------------------------------------------------------------------
  // A partial word is dropped when cs rises: rx_shift_q keeps its value, but
  // the bit counter is cleared, so the next frame shifts in a full fresh word
  // before rx_data changes again.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    wrap_d      = wrap_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (start_frame) begin
      bit_cnt_d = '0;
      wrap_d    = 1'b0;
    end else if (end_frame) begin
      frame_err_d = (bit_cnt_q != '0);
      bit_cnt_d   = '0;
      wrap_d      = 1'b0;
    end else if (active_run) begin
      if (sck_rise) begin
        rx_shift_d = rx_next;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
          wrap_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else if (sck_fall) begin
        wrap_d = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    miso_oe     = (state_q == ST_ACTIVE);
    miso        = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
    tx_ready    = ~buf_valid_q;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    frame_err   = frame_err_q;
    tx_underrun = tx_underrun_q;
  end

endmodule
